// File: rtl/iomem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : iomem_arbiter
//  Purpose  : Round-robin arbiter sharing the single main-RAM iomem port
//             between NUM_REQ requesters. One transaction in flight: the
//             winner's request is latched and driven to RAM until RAM
//             responds or the timeout expires, then the response is routed
//             back to the winner only, followed by a one-cycle GAP.
//  Ports    : clk_i, rst_ni (async, active-low)
//             req_valid_i/req_addr_i/req_wdata_i/req_wstrb_i : packed
//                 per-requester request buses (slice i = requester i)
//             gnt_o, rsp_valid_o, rsp_err_o, rsp_rdata_o : grant/response
//             mem_valid_o/mem_addr_o/mem_wdata_o/mem_wstrb_o : RAM request
//             mem_rsp_valid_i, mem_rdata_i : RAM response
//             busy_o : arbiter not idle
//  Revision : 1.0 - initial release
// ============================================================================
module iomem_arbiter #(
    parameter int NUM_REQ     = 2,
    parameter int ADDR_W      = 32,
    parameter int LINE_W      = 128,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic [NUM_REQ-1:0]          req_valid_i,
    input  logic [NUM_REQ*ADDR_W-1:0]   req_addr_i,
    input  logic [NUM_REQ*LINE_W-1:0]   req_wdata_i,
    input  logic [NUM_REQ*LINE_W/8-1:0] req_wstrb_i,
    output logic [NUM_REQ-1:0]          gnt_o,
    output logic [NUM_REQ-1:0]          rsp_valid_o,
    output logic                        rsp_err_o,
    output logic [LINE_W-1:0]           rsp_rdata_o,
    output logic                        mem_valid_o,
    output logic [ADDR_W-1:0]           mem_addr_o,
    output logic [LINE_W-1:0]           mem_wdata_o,
    output logic [LINE_W/8-1:0]         mem_wstrb_o,
    input  logic                        mem_rsp_valid_i,
    input  logic [LINE_W-1:0]           mem_rdata_i,
    output logic                        busy_o
);

    localparam int c_strb_w = LINE_W / 8;
    localparam int c_own_w  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int c_cnt_w  = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);
    localparam logic [c_own_w-1:0] c_own_last = c_own_w'(NUM_REQ - 1);
    localparam logic [c_own_w:0]   c_num_req  = (c_own_w + 1)'(NUM_REQ);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [c_own_w-1:0]     r_owner;
    logic [c_own_w-1:0]     r_rr_ptr;
    logic [c_cnt_w-1:0]     r_cnt;
    logic [ADDR_W-1:0]      r_addr;
    logic [LINE_W-1:0]      r_wdata;
    logic [c_strb_w-1:0]    r_wstrb;

    logic [2*NUM_REQ-1:0]   w_req_dbl;
    logic [NUM_REQ-1:0]     w_req_rot;
    logic [c_own_w-1:0]     w_off;
    logic [c_own_w:0]       w_sum;
    logic [c_own_w-1:0]     w_pick;
    logic                   w_found;
    logic                   w_start;
    logic                   w_timeout;
    logic                   w_done;
    logic [c_own_w-1:0]     w_ptr_nxt;
    logic [NUM_REQ-1:0]     w_owner_oh;

    // Round-robin pick: rotate the request vector so that bit 0 is the
    // requester at rr_ptr, take the lowest set bit, then map the offset back
    // to an absolute index modulo NUM_REQ (NUM_REQ need not be a power of 2).
    always_comb begin
        w_req_dbl = {req_valid_i, req_valid_i} >> r_rr_ptr;
        w_req_rot = w_req_dbl[NUM_REQ-1:0];
        w_found   = |w_req_rot;
        w_off     = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (w_req_rot[k]) begin
                w_off = k[c_own_w-1:0];
            end
        end
        w_sum = {1'b0, r_rr_ptr} + {1'b0, w_off};
        if (w_sum >= c_num_req) begin
            w_sum = w_sum - c_num_req;
        end
        w_pick = w_sum[c_own_w-1:0];
    end

    assign w_start    = (r_state == ST_IDLE) && w_found;
    assign w_timeout  = (TIMEOUT_CYC != 0) && (r_state == ST_BUSY) && (r_cnt == c_cnt_last);
    // A response coinciding with the timeout wins: it is reported as normal.
    assign w_done     = (r_state == ST_BUSY) && (mem_rsp_valid_i || w_timeout);
    assign w_ptr_nxt  = (r_owner == c_own_last) ? '0 : r_owner + 1'b1;
    assign w_owner_oh = NUM_REQ'(1) << r_owner;

    // State register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; GAP lets the previous owner drop its level-held valid
    // before the next arbitration round samples the requests.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_start) w_state_nxt = ST_BUSY;
            ST_BUSY: if (w_done)  w_state_nxt = ST_GAP;
            ST_GAP:               w_state_nxt = ST_IDLE;
            default:              w_state_nxt = ST_IDLE;
        endcase
    end

    // Transaction latches, owner, round-robin pointer and timeout counter
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_owner  <= '0;
            r_rr_ptr <= '0;
            r_cnt    <= '0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_wstrb  <= '0;
        end else if (w_start) begin
            r_owner <= w_pick;
            r_cnt   <= '0;
            r_addr  <= req_addr_i[w_pick*ADDR_W +: ADDR_W];
            r_wdata <= req_wdata_i[w_pick*LINE_W +: LINE_W];
            r_wstrb <= req_wstrb_i[w_pick*c_strb_w +: c_strb_w];
        end else if (r_state == ST_BUSY) begin
            r_cnt <= r_cnt + 1'b1;
            if (w_done) begin
                r_rr_ptr <= w_ptr_nxt;
            end
        end
    end

    assign busy_o      = (r_state != ST_IDLE);
    assign mem_valid_o = (r_state == ST_BUSY);
    assign mem_addr_o  = r_addr;
    assign mem_wdata_o = r_wdata;
    assign mem_wstrb_o = r_wstrb;
    assign gnt_o       = mem_valid_o ? w_owner_oh : '0;
    assign rsp_valid_o = w_done ? w_owner_oh : '0;
    assign rsp_err_o   = w_done && !mem_rsp_valid_i;
    assign rsp_rdata_o = ((r_state == ST_BUSY) && mem_rsp_valid_i) ? mem_rdata_i : '0;

endmodule
`default_nettype wire

// File: tb/tb_iomem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_iomem_arbiter
//  Purpose  : Self-checking bench for iomem_arbiter. Two instances share all
//             inputs: u_dut (TIMEOUT_CYC = 64) and u_to (TIMEOUT_CYC = 8).
//             Directed sequences, a cycle table and randomized stimulus
//             compared against a transaction-level reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_iomem_arbiter;

    localparam int N    = 2;
    localparam int AW   = 32;
    localparam int LW   = 128;
    localparam int SW   = LW / 8;
    localparam int TO_A = 64;
    localparam int TO_B = 8;
    localparam logic [LW-1:0] C_LINE = 128'hDEAD_C0DE_1234_5678_9ABC_DEF0_0BAD_BEEF;

    logic clk_i  = 1'b0;
    logic rst_ni = 1'b0;
    always #5 clk_i = ~clk_i;

    logic [N-1:0]    req_valid;
    logic [N*AW-1:0] req_addr;
    logic [N*LW-1:0] req_wdata;
    logic [N*SW-1:0] req_wstrb;
    logic            mem_rsp_valid;
    logic [LW-1:0]   mem_rdata;

    logic [N-1:0]    gnt       [2];
    logic [N-1:0]    rsp_valid [2];
    logic            rsp_err   [2];
    logic [LW-1:0]   rsp_rdata [2];
    logic            mem_valid [2];
    logic [AW-1:0]   mem_addr  [2];
    logic [LW-1:0]   mem_wdata [2];
    logic [SW-1:0]   mem_wstrb [2];
    logic            busy      [2];

    iomem_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .LINE_W(LW), .TIMEOUT_CYC(TO_A)) u_dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .req_valid_i(req_valid), .req_addr_i(req_addr), .req_wdata_i(req_wdata), .req_wstrb_i(req_wstrb),
        .gnt_o(gnt[0]), .rsp_valid_o(rsp_valid[0]), .rsp_err_o(rsp_err[0]), .rsp_rdata_o(rsp_rdata[0]),
        .mem_valid_o(mem_valid[0]), .mem_addr_o(mem_addr[0]), .mem_wdata_o(mem_wdata[0]),
        .mem_wstrb_o(mem_wstrb[0]), .mem_rsp_valid_i(mem_rsp_valid), .mem_rdata_i(mem_rdata),
        .busy_o(busy[0])
    );

    iomem_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .LINE_W(LW), .TIMEOUT_CYC(TO_B)) u_to (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .req_valid_i(req_valid), .req_addr_i(req_addr), .req_wdata_i(req_wdata), .req_wstrb_i(req_wstrb),
        .gnt_o(gnt[1]), .rsp_valid_o(rsp_valid[1]), .rsp_err_o(rsp_err[1]), .rsp_rdata_o(rsp_rdata[1]),
        .mem_valid_o(mem_valid[1]), .mem_addr_o(mem_addr[1]), .mem_wdata_o(mem_wdata[1]),
        .mem_wstrb_o(mem_wstrb[1]), .mem_rsp_valid_i(mem_rsp_valid), .mem_rdata_i(mem_rdata),
        .busy_o(busy[1])
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        req_valid     = '0;
        req_addr      = '0;
        req_wdata     = '0;
        req_wstrb     = '0;
        mem_rsp_valid = 1'b0;
        mem_rdata     = '0;
        rst_ni        = 1'b0;
        @(negedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b1;
    endtask

    // ---------------- reference model (per instance) ----------------
    // phase: 0 = idle, 1 = transaction outstanding, 2 = one-cycle gap
    int            m_ph   [2];
    int            m_own  [2];
    int            m_ptr  [2];
    int            m_cnt  [2];
    int            m_to   [2];
    logic [AW-1:0] m_addr [2];
    logic [LW-1:0] m_wdata[2];
    logic [SW-1:0] m_wstrb[2];

    task automatic model_reset();
        for (int j = 0; j < 2; j++) begin
            m_ph[j] = 0; m_own[j] = 0; m_ptr[j] = 0; m_cnt[j] = 0;
            m_addr[j] = '0; m_wdata[j] = '0; m_wstrb[j] = '0;
        end
    endtask

    function automatic bit model_timeout(input int j);
        return (m_ph[j] == 1) && (m_to[j] != 0) && (m_cnt[j] == m_to[j] - 1);
    endfunction

    task automatic model_check(input int j);
        bit          act  = (m_ph[j] == 1);
        bit          fire = act && (mem_rsp_valid || model_timeout(j));
        logic [N-1:0] oh  = N'(1 << m_own[j]);
        chk($sformatf("rnd%0d busy", j),      busy[j],      m_ph[j] != 0);
        chk($sformatf("rnd%0d mem_valid", j), mem_valid[j], act);
        chk($sformatf("rnd%0d gnt", j),       gnt[j],       act ? oh : '0);
        chk($sformatf("rnd%0d addr", j),      mem_addr[j],  m_addr[j]);
        chk($sformatf("rnd%0d wdata", j),     mem_wdata[j], m_wdata[j]);
        chk($sformatf("rnd%0d wstrb", j),     mem_wstrb[j], m_wstrb[j]);
        chk($sformatf("rnd%0d rsp_valid", j), rsp_valid[j], fire ? oh : '0);
        chk($sformatf("rnd%0d rsp_err", j),   rsp_err[j],   fire && !mem_rsp_valid);
        chk($sformatf("rnd%0d rsp_rdata", j), rsp_rdata[j], (act && mem_rsp_valid) ? mem_rdata : '0);
    endtask

    task automatic model_step(input int j);
        bit found = 1'b0;
        case (m_ph[j])
            0: begin
                for (int k = 0; k < N; k++) begin
                    int idx = (m_ptr[j] + k) % N;
                    if (!found && req_valid[idx]) begin
                        found      = 1'b1;
                        m_own[j]   = idx;
                        m_addr[j]  = req_addr[idx*AW +: AW];
                        m_wdata[j] = req_wdata[idx*LW +: LW];
                        m_wstrb[j] = req_wstrb[idx*SW +: SW];
                        m_cnt[j]   = 0;
                        m_ph[j]    = 1;
                    end
                end
            end
            1: begin
                if (mem_rsp_valid || model_timeout(j)) begin
                    m_ptr[j] = (m_own[j] + 1) % N;
                    m_ph[j]  = 2;
                end else begin
                    m_cnt[j]++;
                end
            end
            default: m_ph[j] = 0;
        endcase
    endtask

    // ---------------- cycle table for contention / stray responses ----------------
    typedef struct {
        logic [N-1:0] req;
        logic         mrv;
        logic         busy;
        logic [N-1:0] gnt;
        logic [N-1:0] rsp;
    } vec_t;

    vec_t tbl[13];
    logic [LW-1:0] wd_a;

    initial begin
        m_to[0] = TO_A;
        m_to[1] = TO_B;

        //          req    mrv   busy  gnt    rsp
        tbl[0]  = '{2'b11, 1'b0, 1'b0, 2'b00, 2'b00};  // idle, samples -> req0
        tbl[1]  = '{2'b11, 1'b0, 1'b1, 2'b01, 2'b00};
        tbl[2]  = '{2'b11, 1'b1, 1'b1, 2'b01, 2'b01};  // response to req0
        tbl[3]  = '{2'b11, 1'b1, 1'b1, 2'b00, 2'b00};  // gap, stray response ignored
        tbl[4]  = '{2'b11, 1'b0, 1'b0, 2'b00, 2'b00};  // idle, samples -> req1
        tbl[5]  = '{2'b11, 1'b1, 1'b1, 2'b10, 2'b10};  // 3 cycles after previous response
        tbl[6]  = '{2'b11, 1'b0, 1'b1, 2'b00, 2'b00};
        tbl[7]  = '{2'b11, 1'b1, 1'b0, 2'b00, 2'b00};  // idle, stray response ignored
        tbl[8]  = '{2'b11, 1'b0, 1'b1, 2'b01, 2'b00};  // back to req0
        tbl[9]  = '{2'b11, 1'b1, 1'b1, 2'b01, 2'b01};
        tbl[10] = '{2'b00, 1'b0, 1'b1, 2'b00, 2'b00};
        tbl[11] = '{2'b00, 1'b0, 1'b0, 2'b00, 2'b00};
        tbl[12] = '{2'b00, 1'b1, 1'b0, 2'b00, 2'b00};

        // ---- single read, 16-cycle RAM latency, owner drops valid mid-transaction ----
        do_reset();
        req_addr[31:0] = 32'h8000_0040;
        req_valid      = 2'b01;
        #1 chk("t1 idle busy", busy[0], 1'b0);
        @(negedge clk_i);
        for (int c = 1; c <= 16; c++) begin
            if (c == 4)  req_valid = 2'b00;
            if (c == 16) begin
                mem_rsp_valid = 1'b1;
                mem_rdata     = C_LINE;
            end
            #1;
            chk($sformatf("t1 c%0d mem_valid", c), mem_valid[0], 1'b1);
            chk($sformatf("t1 c%0d rsp_valid", c), rsp_valid[0], (c == 16) ? 2'b01 : 2'b00);
            if (c == 1)  chk("t1 addr", mem_addr[0], 32'h8000_0040);
            if (c == 16) begin
                chk("t1 err", rsp_err[0], 1'b0);
                chk("t1 rdata", rsp_rdata[0], C_LINE);
            end
            @(negedge clk_i);
        end
        mem_rsp_valid = 1'b0;
        #1;
        chk("t1 gap busy", busy[0], 1'b1);
        chk("t1 gap mem_valid", mem_valid[0], 1'b0);
        chk("t1 gap rdata", rsp_rdata[0], '0);
        @(negedge clk_i);
        #1 chk("t1 idle again", busy[0], 1'b0);

        // ---- reset values (rr_ptr was left at 1 above) and contention table ----
        do_reset();
        #1;
        chk("rst busy", busy[0], 1'b0);
        chk("rst mem_valid", mem_valid[0], 1'b0);
        chk("rst gnt", gnt[0], '0);
        chk("rst addr", mem_addr[0], '0);
        chk("rst wdata", mem_wdata[0], '0);
        chk("rst wstrb", mem_wstrb[0], '0);
        chk("rst rsp_valid", rsp_valid[0], '0);
        chk("rst rsp_err", rsp_err[0], 1'b0);
        chk("rst rdata", rsp_rdata[0], '0);
        req_addr  = {32'h0000_1111, 32'h0000_0AAA};
        mem_rdata = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
        for (int i = 0; i < 13; i++) begin
            req_valid     = tbl[i].req;
            mem_rsp_valid = tbl[i].mrv;
            #1;
            chk($sformatf("tbl%0d busy", i),      busy[0],      tbl[i].busy);
            chk($sformatf("tbl%0d gnt", i),       gnt[0],       tbl[i].gnt);
            chk($sformatf("tbl%0d mem_valid", i), mem_valid[0], |tbl[i].gnt);
            chk($sformatf("tbl%0d rsp_valid", i), rsp_valid[0], tbl[i].rsp);
            chk($sformatf("tbl%0d rsp_err", i),   rsp_err[0],   1'b0);
            chk($sformatf("tbl%0d rdata", i),     rsp_rdata[0], (tbl[i].rsp != 0) ? mem_rdata : '0);
            if (tbl[i].gnt != 0)
                chk($sformatf("tbl%0d addr", i), mem_addr[0], tbl[i].gnt[1] ? 32'h0000_1111 : 32'h0000_0AAA);
            @(negedge clk_i);
        end

        // ---- write latch: request inputs changing during the transaction ----
        do_reset();
        wd_a      = 128'hA5A5_0001_5A5A_0002_C3C3_0003_3C3C_0004;
        req_wdata = {wd_a, 128'h0};
        req_wstrb = {16'hFFFF, 16'h0000};
        req_addr  = {32'h0000_2000, 32'h0};
        req_valid = 2'b10;
        @(negedge clk_i);
        req_wdata = {~wd_a, ~wd_a};
        req_wstrb = '0;
        req_addr  = '1;
        #1;
        chk("t3 gnt", gnt[0], 2'b10);
        chk("t3 wdata", mem_wdata[0], wd_a);
        chk("t3 wstrb", mem_wstrb[0], 16'hFFFF);
        chk("t3 addr", mem_addr[0], 32'h0000_2000);
        @(negedge clk_i);
        mem_rsp_valid = 1'b1;
        #1;
        chk("t3 wdata held", mem_wdata[0], wd_a);
        chk("t3 rsp_valid", rsp_valid[0], 2'b10);
        @(negedge clk_i);
        mem_rsp_valid = 1'b0;
        req_valid     = 2'b00;

        // ---- timeout on the TIMEOUT_CYC = 8 instance ----
        do_reset();
        mem_rdata = C_LINE;
        req_valid = 2'b01;
        @(negedge clk_i);
        for (int c = 1; c <= 8; c++) begin
            #1;
            chk($sformatf("t4 c%0d rsp_valid", c), rsp_valid[1], (c == 8) ? 2'b01 : 2'b00);
            if (c == 8) begin
                chk("t4 err", rsp_err[1], 1'b1);
                chk("t4 rdata", rsp_rdata[1], '0);
            end
            @(negedge clk_i);
        end
        req_valid = 2'b00;
        #1;
        chk("t4 gap busy", busy[1], 1'b1);
        chk("t4 gap mem_valid", mem_valid[1], 1'b0);
        @(negedge clk_i);
        #1 chk("t4 idle", busy[1], 1'b0);
        req_valid = 2'b11;
        @(negedge clk_i);
        #1 chk("t4 second owner", gnt[1], 2'b10);
        for (int c = 1; c <= 8; c++) begin
            if (c == 8) mem_rsp_valid = 1'b1;
            #1;
            if (c == 8) begin
                chk("t4 rsp+timeout valid", rsp_valid[1], 2'b10);
                chk("t4 rsp+timeout err", rsp_err[1], 1'b0);
                chk("t4 rsp+timeout rdata", rsp_rdata[1], C_LINE);
            end
            @(negedge clk_i);
        end
        mem_rsp_valid = 1'b0;
        req_valid     = 2'b00;

        // ---- asynchronous reset in the 5th busy cycle ----
        do_reset();
        req_addr[31:0] = 32'h1234_5678;
        req_valid      = 2'b01;
        @(negedge clk_i);
        repeat (4) @(negedge clk_i);
        #2 rst_ni = 1'b0;
        #1;
        chk("t6 busy", busy[0], 1'b0);
        chk("t6 mem_valid", mem_valid[0], 1'b0);
        chk("t6 gnt", gnt[0], '0);
        chk("t6 addr", mem_addr[0], '0);
        chk("t6 rsp_valid", rsp_valid[0], '0);
        @(negedge clk_i);
        rst_ni    = 1'b1;
        req_valid = 2'b10;
        #1 chk("t6 idle", busy[0], 1'b0);
        @(negedge clk_i);
        #1;
        chk("t6 gnt req1", gnt[0], 2'b10);
        chk("t6 mem_valid", mem_valid[0], 1'b1);
        mem_rsp_valid = 1'b1;
        #1 chk("t6 rsp", rsp_valid[0], 2'b10);
        @(negedge clk_i);
        mem_rsp_valid = 1'b0;
        req_valid     = 2'b00;

        // ---- randomized stimulus against the reference model ----
        do_reset();
        model_reset();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            req_valid     = N'($urandom_range(0, 3));
            req_addr      = {$urandom, $urandom};
            req_wdata     = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            req_wstrb     = ($urandom_range(0, 1) == 1) ? 32'($urandom) : '0;
            mem_rsp_valid = ($urandom_range(0, 11) == 0);
            mem_rdata     = {$urandom, $urandom, $urandom, $urandom};
            if ((cyc % 800) == 400) begin
                #2 rst_ni = 1'b0;
                #1;
                chk("rnd reset busy0", busy[0], 1'b0);
                chk("rnd reset busy1", busy[1], 1'b0);
                model_reset();
                @(negedge clk_i);
                rst_ni = 1'b1;
                continue;
            end
            #1;
            model_check(0);
            model_check(1);
            @(posedge clk_i);
            model_step(0);
            model_step(1);
            @(negedge clk_i);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
